// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand path.
//   clog2_min1  : ceil(log2(n)) with a floor of 1, for index widths.
//   MM_ROWS/COLS: default matrix dimensions shared by buffer, PE array and load tracker.
//   WRAP_HOLD / WRAP_STREAM: load-tracker completion modes.
package mm_pkg;

    localparam int MM_ROWS     = 4;
    localparam int MM_COLS     = 4;

    localparam int WRAP_HOLD   = 0;
    localparam int WRAP_STREAM = 1;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : synchronous clear, overrides inc_i
//   inc_i      : advance by one
//   val_o      : current value, 0..N-1
//   wrap_o     : combinational, high when this increment returns the count to 0
module mod_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] val_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // A clear cancels any wrap so chained counters do not advance on it.
    assign wrap_o = inc_i & ~clr_i & (val_q == LAST);

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (inc_i) begin
            val_d = (val_q == LAST) ? '0 : val_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/mat_load_counter.sv
// Element-load tracker for a ROWS x COLS operand matrix.
//   clk, rst_n      : clock and asynchronous active-low reset
//   clr             : synchronous clear of all state
//   register_ready  : one element written this cycle
//   consume         : downstream took the full matrix (hold mode only)
//   row_idx/col_idx : position of the next element
//   count           : elements accepted in the current matrix
//   row_done        : pulse after the last column of a row is accepted
//   full            : matrix complete (held, or 1-cycle pulse in stream mode)
//   overflow        : sticky, an element arrived while full was held
module mat_load_counter
    import mm_pkg::*;
#(
    parameter int ROWS  = MM_ROWS,
    parameter int COLS  = MM_COLS,
    parameter int WRAP  = WRAP_HOLD,
    parameter int ROW_W = clog2_min1(ROWS),
    parameter int COL_W = clog2_min1(COLS),
    parameter int CNT_W = $clog2(ROWS * COLS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             register_ready,
    input  logic             consume,
    output logic [ROW_W-1:0] row_idx,
    output logic [COL_W-1:0] col_idx,
    output logic [CNT_W-1:0] count,
    output logic             row_done,
    output logic             full,
    output logic             overflow
);

    localparam logic             STREAM = (WRAP == WRAP_STREAM);
    localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(ROWS * COLS);

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             row_done_q, row_done_d;

    logic             accept;
    logic             col_wrap;
    logic             row_wrap;
    logic [CNT_W-1:0] count_base;

    // In hold mode a held matrix blocks new elements unless it is consumed
    // in the same cycle; the element then starts the next matrix.
    assign accept = register_ready & (~full_q | STREAM | consume);

    mod_counter #(.N(COLS), .W(COL_W)) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .inc_i  (accept),
        .val_o  (col_idx),
        .wrap_o (col_wrap)
    );

    mod_counter #(.N(ROWS), .W(ROW_W)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .inc_i  (col_wrap),
        .val_o  (row_idx),
        .wrap_o (row_wrap)
    );

    // A completed count restarts from zero on the next accepted element.
    assign count_base = (count_q == TOTAL) ? '0 : count_q;

    always_comb begin
        count_d    = count_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        row_done_d = 1'b0;
        if (clr) begin
            count_d    = '0;
            full_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            row_done_d = col_wrap;
            if (accept) begin
                count_d = count_base + CNT_W'(1);
            end else if (!STREAM && full_q && consume) begin
                count_d = '0;
            end

            if (STREAM) begin
                full_d = row_wrap;
            end else if (row_wrap) begin
                full_d = 1'b1;
            end else if (full_q && consume) begin
                full_d = 1'b0;
            end

            if (!STREAM && full_q && register_ready && !consume) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            row_done_q <= row_done_d;
        end
    end

    assign count    = count_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign row_done = row_done_q;

endmodule

// File: doc/mat_load_counter.md
Name: mat_load_counter

Overview:
Parametrised element-load tracker for the matrix-multiply operand buffers. It counts `register_ready` strobes, one per element written into an operand register bank, and tracks the current row and column of a ROWS x COLS matrix. It raises `full` once the whole matrix is loaded and holds it until the compute array consumes the matrix. This block is the successor of the fixed-size `full` counter. It adds row/column indexing, row-complete pulses, a consume handshake, an overflow flag and a wrap mode for streaming operands.

Parameters:
- ROWS, 4, matrix rows; must be 1 or more.
- COLS, 4, matrix columns; must be 1 or more.
- WRAP, 0, 0 = hold `full` until `consume`; 1 = free-running, `full` is a 1-cycle pulse per matrix.
- ROW_W, $clog2(ROWS) with a minimum of 1, width of `row_idx`.
- COL_W, $clog2(COLS) with a minimum of 1, width of `col_idx`.
- CNT_W, $clog2(ROWS*COLS+1), width of `count`.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear; highest priority after reset.
- register_ready, input, 1, sampled high = one element written this cycle.
- consume, input, 1, downstream has taken the full matrix; ignored when WRAP=1.
- row_idx, output, ROW_W, row of the next element to be written.
- col_idx, output, COL_W, column of the next element to be written.
- count, output, CNT_W, elements accepted in the current matrix (0..ROWS*COLS).
- row_done, output, 1, 1-cycle pulse after the last column of a row is accepted.
- full, output, 1, matrix complete.
- overflow, output, 1, sticky; an element arrived while `full` was held.

Behaviour:
- Reset (`rst_n`=0, asynchronous): all outputs become 0 immediately. They stay 0 until the first `clk` edge with `rst_n`=1.
- `clr`=1: at the next edge every output is 0, `overflow` included. `register_ready` and `consume` in the same cycle are ignored.
- All outputs are registered. An accepted element is visible on `count`, `row_idx`, `col_idx`, `row_done` and `full` one cycle after the edge that samples it.
- Accept condition: `accept = register_ready & (~full | WRAP | consume)`.
- On accept, column and row advance as follows:
  - `col_idx` increments.
  - When `col_idx` = COLS-1: `col_idx` returns to 0, `row_done` pulses, and `row_idx` increments.
  - When `row_idx` = ROWS-1 at that point: `row_idx` returns to 0 (matrix complete).
- On accept, `count` increments. When the matrix completes, `count` = ROWS*COLS.
- WRAP=0:
  - On completion `full` is set and held. `count` holds at ROWS*COLS and the indices sit at 0,0.
  - `consume` while `full`: `full` and `count` clear at the next edge.
  - `consume` without `full`: no effect.
  - `register_ready` while `full` with no `consume`: the element is dropped, indices are unchanged, and `overflow` is set (sticky until `clr` or reset).
  - `consume` and `register_ready` in the same cycle while `full`: the element is accepted as element 0 of the next matrix. Next cycle: `full`=0, `count`=1, `col_idx`=1 (or `row_idx`=1 and `col_idx`=0 if COLS=1).
- WRAP=1:
  - On completion `full` pulses for exactly 1 cycle and `count` becomes ROWS*COLS for that cycle.
  - The next accepted element restarts `count` at 1. Counting never stalls, and `overflow` stays 0.
- Degenerate sizes:
  - ROWS=COLS=1: every accept both pulses `row_done` and completes the matrix.
  - COLS=1: `row_done` pulses on every accept.
- `row_done` and `full` may assert in the same cycle on the last element of a matrix.
- Reset asserted mid-matrix: the partial count is discarded. There is no resume.

Decomposition:
- Shared package `mm_pkg`:
  - clog2-based width helper function.
  - Default matrix dimension constants (MM_ROWS, MM_COLS) shared with the operand buffer and PE array.
  - Mode localparams WRAP_HOLD=0 and WRAP_STREAM=1.
- One natural sub-module, `mod_counter`: a parametrised modulo-N counter with `inc`, `clr` and a wrap output. It is instantiated twice, for column and row, with the column wrap chained into the row increment. The top level holds `count`, the `full`/`overflow` logic and the accept gating.

Test Plan:
- ROWS=2, COLS=3, WRAP=0; reset, then 6 consecutive strobes -> `row_done` pulses after strobes 3 and 6; `full`=1 and `count`=6 one cycle after strobe 6; indices 0,0.
- Same config: hold `full`, give 2 extra strobes -> `count` stays 6, indices unchanged, `overflow`=1. Then `consume` -> `full`=0, `count`=0, `overflow` still 1. Then `clr` -> `overflow`=0.
- Same config: `full`, then `consume` and `register_ready` in the same cycle -> next cycle `full`=0, `count`=1, `col_idx`=1, `row_idx`=0.
- ROWS=2, COLS=2, WRAP=1; 9 continuous strobes -> `full` high for 1 cycle after strobes 4 and 8; `count` sequence 1,2,3,4,1,2,3,4,1; `overflow` stays 0.
- ROWS=2, COLS=3, WRAP=0; 4 strobes, then `rst_n` pulsed low between clock edges -> all outputs 0 immediately. After release, 6 strobes give `full`=1.
- ROWS=1, COLS=1; single strobe -> `row_done`=1 and `full`=1 in the same cycle, `count`=1. `consume` with no `full` pending afterwards has no effect.
